// File: rtl/inst_pos_responder_if.sv
// Bus bundles for the instruction-fetch responder: the initiator-facing fetch
// port and the read-only backing-memory port.
interface inst_pos_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        error;

    modport master (output req, addr, input ack, data, error);
    modport slave  (input req, addr, output ack, data, error);
endinterface

interface inst_mem_if #(
    parameter int MEM_AW = 10
);
    logic              req;
    logic [MEM_AW-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/inst_pos_responder.sv
// Serves word-aligned instruction fetches from a byte-address window by
// issuing single reads to a backing memory, with optional ack delay and timeout.
module inst_pos_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [31:0] SIZE_BYTES  = 32'h1000,
    parameter int          MEM_AW      = 10,
    parameter int          WAIT_CYCLES = 0,
    parameter int          TIMEOUT     = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    inst_pos_if.slave  inst_pos,
    inst_mem_if.master mem
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAITR, HOLD, ACK} state_t;

    // Window bounds are 33 bits wide so a window ending at 0xFFFF_FFFF cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES} - 33'd1;
    localparam int          TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]      HOLD_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state_reg, state_next;
    logic [MEM_AW-1:0] mem_addr_reg, mem_addr_next;
    logic [31:0]       data_reg, data_next;
    logic              error_reg, error_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic [3:0]        hold_cnt_reg, hold_cnt_next;
    logic              abort_reg, abort_next;

    logic        addr_legal;
    logic [32:0] addr_ext;
    logic        drop_ack;

    assign addr_ext   = {1'b0, inst_pos.addr};
    assign addr_legal = (addr_ext >= WIN_LO) && (addr_ext <= WIN_HI) &&
                        (inst_pos.addr[1:0] == 2'b00);
    // Once the initiator lets go of req the transaction still finishes, silently.
    assign drop_ack   = abort_reg | ~inst_pos.req;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            mem_addr_reg <= '0;
            data_reg     <= '0;
            error_reg    <= 1'b0;
            to_cnt_reg   <= '0;
            hold_cnt_reg <= '0;
            abort_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mem_addr_reg <= mem_addr_next;
            data_reg     <= data_next;
            error_reg    <= error_next;
            to_cnt_reg   <= to_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            abort_reg    <= abort_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mem_addr_next = mem_addr_reg;
        data_next     = data_reg;
        error_next    = error_reg;
        to_cnt_next   = to_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        abort_next    = abort_reg;

        case (state_reg)
            IDLE: begin
                abort_next = 1'b0;
                if (inst_pos.req) begin
                    if (addr_legal) begin
                        mem_addr_next = MEM_AW'((inst_pos.addr - BASE_ADDR) >> 2);
                        state_next    = ISSUE;
                    end else begin
                        data_next  = '0;
                        error_next = 1'b1;
                        state_next = ACK;
                    end
                end
            end
            ISSUE: begin
                abort_next = drop_ack;
                if (mem.gnt) begin
                    to_cnt_next = '0;
                    state_next  = WAITR;
                end
            end
            WAITR: begin
                abort_next = drop_ack;
                if (mem.rvalid) begin
                    data_next     = mem.rdata;
                    error_next    = mem.err;
                    hold_cnt_next = '0;
                    if (WAIT_CYCLES > 0) begin
                        state_next = HOLD;
                    end else begin
                        state_next = drop_ack ? IDLE : ACK;
                    end
                end else if (to_cnt_reg == TO_LAST) begin
                    data_next  = '0;
                    error_next = 1'b1;
                    state_next = drop_ack ? IDLE : ACK;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            HOLD: begin
                abort_next = drop_ack;
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = drop_ack ? IDLE : ACK;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 4'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign inst_pos.ack   = (state_reg == ACK);
    assign inst_pos.data  = (state_reg == ACK) ? data_reg : 32'h0;
    assign inst_pos.error = (state_reg == ACK) ? error_reg : 1'b0;
    assign mem.req        = (state_reg == ISSUE);
    assign mem.addr       = mem_addr_reg;
endmodule

// File: tb/tb_inst_pos_responder.sv
// Drives two responders (no ack delay at base 0, three-cycle delay at base 0x2000)
// and compares every fetch against latency/data/error rules computed here.
module tb_inst_pos_responder;
    localparam int TIMEOUT = 64;
    localparam logic [31:0] SIZE = 32'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_v[2];
    logic [31:0] addr_v[2];
    logic        gnt_v[2];
    logic        rvalid_v[2];
    logic [31:0] rdata_v[2];
    logic        merr_v[2];
    logic        ack_v[2];
    logic [31:0] data_v[2];
    logic        err_v[2];
    logic        mreq_v[2];
    logic [9:0]  maddr_v[2];

    int checks = 0;
    int failures = 0;

    inst_pos_if ip0();
    inst_pos_if ip1();
    inst_mem_if #(.MEM_AW(10)) mi0();
    inst_mem_if #(.MEM_AW(10)) mi1();

    assign ip0.req = req_v[0];  assign ip0.addr = addr_v[0];
    assign ip1.req = req_v[1];  assign ip1.addr = addr_v[1];
    assign mi0.gnt = gnt_v[0];  assign mi0.rvalid = rvalid_v[0];
    assign mi0.rdata = rdata_v[0]; assign mi0.err = merr_v[0];
    assign mi1.gnt = gnt_v[1];  assign mi1.rvalid = rvalid_v[1];
    assign mi1.rdata = rdata_v[1]; assign mi1.err = merr_v[1];
    assign ack_v[0] = ip0.ack;  assign data_v[0] = ip0.data;  assign err_v[0] = ip0.error;
    assign ack_v[1] = ip1.ack;  assign data_v[1] = ip1.data;  assign err_v[1] = ip1.error;
    assign mreq_v[0] = mi0.req; assign maddr_v[0] = mi0.addr;
    assign mreq_v[1] = mi1.req; assign maddr_v[1] = mi1.addr;

    inst_pos_responder #(
        .BASE_ADDR(32'h0), .SIZE_BYTES(SIZE), .MEM_AW(10),
        .WAIT_CYCLES(0), .TIMEOUT(TIMEOUT)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .inst_pos(ip0.slave), .mem(mi0.master)
    );

    inst_pos_responder #(
        .BASE_ADDR(32'h2000), .SIZE_BYTES(SIZE), .MEM_AW(10),
        .WAIT_CYCLES(3), .TIMEOUT(TIMEOUT)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .inst_pos(ip1.slave), .mem(mi1.master)
    );

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0 : 32'h2000;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit is_legal(input int d, input logic [31:0] a);
        logic [32:0] lo, hi, ax;
        lo = {1'b0, base_of(d)};
        hi = lo + {1'b0, SIZE} - 33'd1;
        ax = {1'b0, a};
        return (ax >= lo) && (ax <= hi) && (a[1:0] == 2'b00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input int d, input string tag);
        chk($sformatf("d%0d_%s_ack", d, tag), {31'b0, ack_v[d]}, 32'h0);
        chk($sformatf("d%0d_%s_data", d, tag), data_v[d], 32'h0);
        chk($sformatf("d%0d_%s_err", d, tag), {31'b0, err_v[d]}, 32'h0);
        chk($sformatf("d%0d_%s_mreq", d, tag), {31'b0, mreq_v[d]}, 32'h0);
        chk($sformatf("d%0d_%s_maddr", d, tag), {22'b0, maddr_v[d]}, 32'h0);
    endtask

    // One fetch: gd = cycles gnt is withheld, rv = cycles from gnt to rvalid,
    // abort_k > 0 drops req after that many cycles, tight ends right at the ack.
    task automatic fetch(input int d, input logic [31:0] a, input int gd, input int rv,
                         input logic [31:0] rd, input logic me, input int abort_k,
                         input bit tight);
        int k, ack_cnt, ack_k, mreq_cnt, gnt_k, exp_lat, limit, pend_k, stop_k;
        logic [31:0] ack_data, exp_data;
        logic ack_err, exp_err;
        logic [9:0] ma;
        bit lg, tmo, ab, leak;

        lg  = is_legal(d, a);
        tmo = lg && (rv > TIMEOUT);
        ab  = (abort_k > 0);
        exp_lat  = !lg ? 1 : (tmo ? gd + TIMEOUT + 2 : gd + rv + 2 + wait_of(d));
        exp_data = (lg && !tmo) ? rd : 32'h0;
        exp_err  = !lg || tmo || me;
        pend_k   = lg ? 1 + gd + rv : 0;
        limit    = ((exp_lat > pend_k) ? exp_lat : pend_k) + 4;
        stop_k   = limit;
        k = 0; ack_cnt = 0; ack_k = -1; mreq_cnt = 0; gnt_k = -1;
        ack_data = '0; ack_err = 1'b0; ma = '0; leak = 0;

        @(negedge clk);
        req_v[d] = 1'b1;
        addr_v[d] = a;
        while (k < limit && k < stop_k) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            gnt_v[d] = 1'b0; rvalid_v[d] = 1'b0; rdata_v[d] = '0; merr_v[d] = 1'b0;
            if (mreq_v[d]) begin
                mreq_cnt++;
                if (mreq_cnt == 1) ma = maddr_v[d];
                if (mreq_cnt == gd + 1) begin
                    gnt_v[d] = 1'b1;
                    gnt_k = k;
                end
            end
            if (gnt_k > 0 && k == gnt_k + rv) begin
                rvalid_v[d] = 1'b1; rdata_v[d] = rd; merr_v[d] = me;
            end
            if (ack_v[d]) begin
                ack_cnt++;
                if (ack_cnt == 1) begin
                    ack_k = k; ack_data = data_v[d]; ack_err = err_v[d];
                    req_v[d] = 1'b0;
                    stop_k = tight ? k : ((k + 1 > pend_k + 1) ? k + 1 : pend_k + 1);
                end
            end else if (data_v[d] !== 32'h0) begin
                leak = 1;
            end
            if (ab && k == abort_k) req_v[d] = 1'b0;
        end
        req_v[d] = 1'b0;
        gnt_v[d] = 1'b0; rvalid_v[d] = 1'b0; rdata_v[d] = '0; merr_v[d] = 1'b0;

        chk($sformatf("d%0d_a%0h_ackcount", d, a), 32'(ack_cnt), ab ? 32'd0 : 32'd1);
        if (!ab) begin
            chk($sformatf("d%0d_a%0h_latency", d, a), 32'(ack_k), 32'(exp_lat));
            chk($sformatf("d%0d_a%0h_data", d, a), ack_data, exp_data);
            chk($sformatf("d%0d_a%0h_error", d, a), {31'b0, ack_err}, {31'b0, exp_err});
        end
        chk($sformatf("d%0d_a%0h_mreqcycles", d, a), 32'(mreq_cnt), lg ? 32'(gd + 1) : 32'd0);
        if (lg) chk($sformatf("d%0d_a%0h_maddr", d, a), {22'b0, ma},
                    {22'b0, 10'((a - base_of(d)) >> 2)});
        chk($sformatf("d%0d_a%0h_dataleak", d, a), {31'b0, leak}, 32'h0);
    endtask

    initial begin
        int acks, mreqs, cat;
        logic [31:0] a, b;

        for (int d = 0; d < 2; d++) begin
            req_v[d] = 0; addr_v[d] = '0; gnt_v[d] = 0;
            rvalid_v[d] = 0; rdata_v[d] = '0; merr_v[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet(0, "reset");
        chk_quiet(1, "reset");
        rst = 1'b0;

        // Basic fetch, illegal/misaligned fetches, window edges.
        fetch(0, 32'h10, 0, 1, 32'hDEADBEEF, 1'b0, 0, 0);
        fetch(0, 32'h1000, 0, 1, 32'h1111_1111, 1'b0, 0, 0);
        fetch(0, 32'h2, 0, 1, 32'h2222_2222, 1'b0, 0, 0);
        fetch(0, 32'hFFC, 0, 1, 32'h3333_3333, 1'b0, 0, 0);
        fetch(1, 32'h1FFC, 0, 1, 32'h4444_4444, 1'b0, 0, 0);
        fetch(1, 32'h2FFC, 0, 1, 32'h5555_5555, 1'b0, 0, 0);
        fetch(1, 32'h3000, 0, 1, 32'h6666_6666, 1'b0, 0, 0);
        // Withheld grant with ack delay.
        fetch(1, 32'h2040, 5, 1, 32'hCAFE_F00D, 1'b0, 0, 0);
        // Timeout, then a late rvalid that must not produce an ack.
        fetch(0, 32'h20, 0, TIMEOUT + 6, 32'h7777_7777, 1'b0, 0, 0);
        // Memory error.
        fetch(0, 32'h24, 1, 2, 32'h8888_8888, 1'b1, 0, 0);
        // Abort mid-transaction, then a normal fetch proves the FSM is back in IDLE.
        fetch(1, 32'h2008, 1, 2, 32'h9999_9999, 1'b0, 2, 0);
        fetch(1, 32'h200C, 0, 1, 32'hAAAA_AAAA, 1'b0, 0, 0);

        // Reset while waiting for read data.
        @(negedge clk);
        req_v[0] = 1'b1; addr_v[0] = 32'h30;
        @(posedge clk); @(negedge clk);
        gnt_v[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        gnt_v[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        req_v[0] = 1'b0;
        chk_quiet(0, "midreset");
        acks = 0; mreqs = 0;
        rvalid_v[0] = 1'b1; rdata_v[0] = 32'hBAD0_BAD0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            rvalid_v[0] = 1'b0; rdata_v[0] = '0;
            if (ack_v[0]) acks++;
            if (mreq_v[0]) mreqs++;
        end
        chk("d0_midreset_noack", 32'(acks), 32'd0);
        chk("d0_midreset_nomreq", 32'(mreqs), 32'd0);
        fetch(0, 32'h34, 0, 1, 32'h1234_5678, 1'b0, 0, 0);

        // Back-to-back fetches with one idle cycle between them.
        fetch(0, 32'h0, 0, 1, 32'h0BAD_F00D, 1'b0, 0, 1);
        fetch(0, 32'h4, 0, 1, 32'hFEED_FACE, 1'b0, 0, 1);
        fetch(1, 32'h2000, 0, 2, 32'h0102_0304, 1'b0, 0, 1);
        fetch(1, 32'h2004, 1, 1, 32'h0506_0708, 1'b0, 0, 1);

        // Randomized fetches on both responders.
        for (int i = 0; i < 24; i++) begin
            int d;
            d = i % 2;
            cat = $urandom_range(0, 5);
            b = base_of(d);
            if (cat == 0)
                a = (d == 1 && $urandom_range(0, 1) == 1) ? b - 32'(4 * $urandom_range(1, 16))
                                                          : b + SIZE + 32'(4 * $urandom_range(0, 255));
            else if (cat == 1)
                a = b + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
            else
                a = b + 32'(4 * $urandom_range(0, 1023));
            fetch(d, a, $urandom_range(0, 3), $urandom_range(1, 4), $urandom,
                  ($urandom_range(0, 7) == 0), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
